// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register file write port
// Grants one writeback requester per cycle and registers the winning write toward the register file.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          prio0,
    input  logic                          stall,
    output logic                          WriteEnable,
    output logic [ADDR_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]         write_data_in,
    output logic                          r0_drop,
    output logic [CNT_WIDTH-1:0]          write_count
);

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]    L_NUM_REQ = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]  L_LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] L_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [IDX_W-1:0]      r_last_grant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_drop;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_prio_hit;
    logic                  w_rr_found;
    logic [IDX_W-1:0]      w_rr_idx;
    logic [IDX_W:0]        w_probe;
    logic                  w_grant_any;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Search starts one past the last round-robin winner and wraps modulo NUM_REQ.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_probe    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_probe = {1'b0, r_last_grant} + (IDX_W+1)'(k);
            if (w_probe >= L_NUM_REQ) begin
                w_probe = w_probe - L_NUM_REQ;
            end
            if (!w_rr_found && req_valid[w_probe[IDX_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_probe[IDX_W-1:0];
            end
        end
    end

    assign w_prio_hit  = prio0 & req_valid[0];
    assign w_grant_any = reset & ~stall & (w_prio_hit | w_rr_found);
    assign w_grant_idx = w_prio_hit ? '0 : w_rr_idx;
    assign w_xfer      = |(req_ready & req_valid);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant_any && (w_grant_idx == IDX_W'(i));
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Override grants to requester 0 must not disturb the rotation of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= L_LAST_RST;
        end else if (w_xfer && !w_prio_hit) begin
            r_last_grant <= w_grant_idx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_drop <= 1'b0;
        end else if (w_xfer) begin
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
            // Register 0 is hardwired zero: acknowledge the write but never commit it.
            r_we   <= (w_sel_addr != '0);
            r_drop <= (w_sel_addr == '0);
        end else begin
            r_we   <= 1'b0;
            r_drop <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_xfer && (r_count != L_CNT_MAX)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign WriteEnable   = r_we;
    assign write_address = r_addr;
    assign write_data_in = r_data;
    assign r0_drop       = r_drop;
    assign write_count   = r_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized self-checking bench for regfile_write_arbiter
// A behavioural arbiter/regfile model predicts every grant and registered output.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready, req_ready4;
    logic            prio0, stall;
    logic            we, we4;
    logic [AW-1:0]   waddr, waddr4;
    logic [DW-1:0]   wdata, wdata4;
    logic            drop, drop4;
    logic [15:0]     cnt;
    logic [3:0]      cnt4;

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clock(clk), .reset(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .prio0(prio0), .stall(stall),
        .WriteEnable(we), .write_address(waddr), .write_data_in(wdata),
        .r0_drop(drop), .write_count(cnt)
    );

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut4 (
        .clock(clk), .reset(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready4), .prio0(prio0), .stall(stall),
        .WriteEnable(we4), .write_address(waddr4), .write_data_in(wdata4),
        .r0_drop(drop4), .write_count(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file as seen by the DUT outputs, and the model's own copy.
    logic [DW-1:0] rf_dut [32];
    logic [DW-1:0] rf_ref [32];
    always @(posedge clk) if (we) rf_dut[waddr] <= wdata;

    int          m_last;
    logic        m_we, m_drop;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_cnt, m_cnt4;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_we = 1'b0; m_drop = 1'b0; m_addr = '0; m_data = '0;
        m_cnt = 0; m_cnt4 = 0;
    endtask

    function automatic int model_grant();
        if (!rst_n || stall) return -1;
        if (prio0 && req_valid[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    // One clock: check the grant, take the edge, update the model, check registered outputs.
    task automatic step();
        int g;
        logic [N-1:0] exp_ready;
        logic [AW-1:0] a;
        g = model_grant();
        exp_ready = (g < 0) ? '0 : N'(1 << g);
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        if (m_we) rf_ref[m_addr] = m_data;
        if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            m_addr = a;
            m_data = req_data[g*DW +: DW];
            m_we   = (a != 0);
            m_drop = (a == 0);
            if (m_cnt  < 65535) m_cnt++;
            if (m_cnt4 < 15)    m_cnt4++;
            if (!(prio0 && req_valid[0])) m_last = g;
        end else begin
            m_we = 1'b0; m_drop = 1'b0;
        end
        #1;
        check("WriteEnable",   64'(we),    64'(m_we));
        check("write_address", 64'(waddr), 64'(m_addr));
        check("write_data_in", 64'(wdata), 64'(m_data));
        check("r0_drop",       64'(drop),  64'(m_drop));
        check("write_count",   64'(cnt),   64'(m_cnt));
        check("write_count4",  64'(cnt4),  64'(m_cnt4));
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '1;
        model_reset();
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_we",    64'(we),        64'd0);
        check("rst_cnt",   64'(cnt),       64'd0);
        @(posedge clk); #1;
        check("rst_hold_we", 64'(we), 64'd0);
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_dut[i] = '0;
            rf_ref[i] = '0;
        end
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        prio0 = 1'b0; stall = 1'b0;
        #12;

        // First grant after reset goes to requester 0.
        do_reset();
        req_valid = 3'b111;
        step();
        check("first_grant0", 64'(waddr == req_addr[0 +: AW]), 64'd1);

        // Round-robin rotation across 6 cycles.
        do_reset();
        set_req(0, 5'd1, 32'hAAAA_AAAA);
        set_req(1, 5'd2, 32'hBBBB_BBBB);
        set_req(2, 5'd3, 32'hCCCC_CCCC);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) step();
        check("rr_count", 64'(cnt), 64'd6);

        // Register 0 drop, then idle.
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'hDEAD_BEEF);
        step();
        req_valid = 3'b000;
        step();

        // prio0 override keeps the pointer; requester 2 wins once released.
        prio0 = 1'b1;
        req_valid = 3'b101;
        set_req(2, 5'd9, 32'h0000_0099);
        for (int c = 0; c < 3; c++) step();
        prio0 = 1'b0;
        step();
        check("after_prio_addr", 64'(waddr), 64'd9);
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;

        // Same-address contention: later grant wins register 5.
        do_reset();
        set_req(0, 5'd5, 32'h11);
        set_req(1, 5'd5, 32'h22);
        req_valid = 3'b011;
        step();
        req_valid = 3'b010;
        step();
        req_valid = 3'b000;
        step();
        check("contend_rf5", 64'(rf_dut[5]), 64'h22);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            prio0 = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < N; i++) set_req(i, AW'($urandom_range(0, 31)), $urandom);
            step();
        end
        prio0 = 1'b0; stall = 1'b0; req_valid = '0;
        step();
        for (int i = 0; i < 32; i++) check("rf_content", 64'(rf_dut[i]), 64'(rf_ref[i]));

        // Saturation of the narrow counter.
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) set_req(i, 5'd7, 32'h77);
        for (int c = 0; c < 20; c++) step();
        check("sat4", 64'(cnt4), 64'd15);

        // Asynchronous reset mid-cycle while a write is pending.
        req_valid = 3'b001;
        step();
        check("pre_async_we", 64'(we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_we",    64'(we),        64'd0);
        check("async_ready", 64'(req_ready), 64'd0);
        check("async_cnt",   64'(cnt),       64'd0);
        model_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters, e.g. ALU writeback, load writeback and host/debug loader.
- Uses round-robin arbitration, with an optional fixed-priority override for requester 0.
- Registers the winning write onto the register file's WriteEnable, write_address and write_data_in inputs.
- Sits between the pipeline writeback stages and the register file.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width (32 registers).
- CNT_WIDTH, 16, width of the saturating accepted-write counter.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination addresses; requester i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot-or-zero grant; combinational.
- prio0  in  1  when high, requester 0 has fixed top priority.
- stall  in  1  blocks all grants while high.
- WriteEnable  out  1  register file write enable; registered.
- write_address  out  ADDR_WIDTH  register file write address; registered.
- write_data_in  out  DATA_WIDTH  register file write data; registered.
- r0_drop  out  1  one-cycle pulse: an accepted write targeted register 0 and was discarded.
- write_count  out  CNT_WIDTH  number of accepted writes, saturating.

Behaviour:
- Reset (reset low, async):
  - WriteEnable=0, write_address=0, write_data_in=0, r0_drop=0, write_count=0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins the first round-robin search.
  - Reset mid-operation discards any registered write; WriteEnable drops immediately.
- Grant (combinational):
  - If stall=1 or reset is low: req_ready=0.
  - Else if prio0=1 and req_valid[0]=1: req_ready = one-hot bit 0.
  - Else: search req_valid starting at index (last_grant+1) mod NUM_REQ, wrapping. The first set bit gets req_ready. None set: req_ready=0.
  - At most one req_ready bit is high per cycle. req_ready never depends on req_addr or req_data.
- Transfer: requester i transfers on a posedge where req_valid[i] and req_ready[i] are both high. Requesters hold valid/addr/data stable until transfer (protocol rule; the RTL does not check it).
- Pointer update:
  - last_grant := i only for round-robin transfers.
  - A prio0 override grant leaves last_grant unchanged.
  - No transfer: unchanged.
- Output register, on a transfer at edge N (all visible in cycle N+1, after edge N):
  - write_address <= req_addr[i]; write_data_in <= req_data[i].
  - If req_addr[i]==0: WriteEnable <= 0 and r0_drop <= 1. Register 0 is hardwired zero; the write is acknowledged but discarded.
  - Otherwise: WriteEnable <= 1 and r0_drop <= 0.
  - The register file commits at edge N+1, so accept-to-commit latency is 1 cycle.
  - No transfer: WriteEnable <= 0, r0_drop <= 0; write_address and write_data_in hold their values.
- write_count:
  - Increments by 1 on every transfer, including register 0 drops.
  - Saturates at all-ones; no wrap.
- Throughput: one accepted write per cycle, with back-to-back grants allowed.
- Fairness: with all requesters continuously valid and prio0=0, grants rotate 0,1,2,0,... Any valid requester waits at most NUM_REQ-1 cycles of other grants.
- Same-address contention: two requesters targeting the same address are serialised in grant order; the later grant's data is the final register content. No merging.
- stall asserted while a write sits in the output register: that write still completes (WriteEnable stays high for its cycle). Only new grants are blocked.
- prio0 held high with req_valid[0] continuously high starves the others. This is intended (host/debug load mode).

Test Plan:
- Reset: hold reset low with all req_valid high → req_ready=0, WriteEnable=0, write_count=0. Release → first grant goes to req 0.
- Round-robin: all three valid continuously for 6 cycles with addrs 1/2/3 and data A/B/C → req_ready sequence 001,010,100,001,010,100. WriteEnable high from cycle 2 on. write_address sequence 1,2,3,1,2,3 one cycle after each grant. write_count=6.
- Register 0 drop: req 1 writes addr 0, data 0xDEADBEEF → next cycle WriteEnable=0, r0_drop=1 for exactly 1 cycle, write_count increments.
- Priority/stall: prio0=1 with req 0 and req 2 valid for 3 cycles → req 0 granted 3 times and last_grant unchanged; then prio0=0 → req 2 granted next. stall=1 → req_ready=0 and WriteEnable=0 from the following cycle.
- Contention: req 0 and req 1 both target addr 5 with 0x11 and 0x22 → two consecutive writes; register 5 ends at the later-granted value (0x22 from reset state).
- Saturation and async reset: preload near-full via many transfers with CNT_WIDTH=4 → write_count stops at 15. Assert reset mid-cycle while WriteEnable=1 → WriteEnable falls immediately without waiting for a clock edge.
